// File: rtl/master_example_test.sv
// Avalon-MM test master: writes an address-derived pattern over NUM_WORDS words,
// or reads the same region back and counts mismatches against that pattern.
module master_example_test #(
  parameter int unsigned ADDR_W    = 26,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_WORDS = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              n_action,
  input  logic              rdwr_cntl,
  input  logic [ADDR_W-1:0] address,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [8:0]        error_count
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StReadReq,
    StReadWait,
    StDone
  } state_e;

  localparam logic [8:0] LastK = 9'(NUM_WORDS - 1);
  localparam logic [8:0] ErrMax = 9'd511;

  state_e            state_q, state_d;
  logic              sync1_q, sync2_q, prev_q;
  logic              start;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [8:0]        k_q, k_d;
  logic [8:0]        err_q, err_d;
  logic [DATA_W-1:0] pattern;
  logic              last;
  logic              unused_addr_lsbs;

  // Word alignment discards the two low address bits.
  assign unused_addr_lsbs = ^address[1:0];

  // Synchronizer idles high so a reset release never looks like a falling edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= n_action;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign start = prev_q & ~sync2_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      base_q  <= '0;
      k_q     <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  assign avm_address = base_q + ADDR_W'({k_q, 2'b00});
  assign pattern     = DATA_W'(avm_address) ^ DATA_W'(32'hA5A5_0000);
  assign last        = (k_q == LastK);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    k_d       = k_q;
    err_d     = err_q;
    avm_read  = 1'b0;
    avm_write = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          base_d  = {address[ADDR_W-1:2], 2'b00};
          k_d     = '0;
          err_d   = '0;
          state_d = rdwr_cntl ? StReadReq : StWrite;
        end
      end
      StWrite: begin
        avm_write = 1'b1;
        if (!avm_waitrequest) begin
          k_d = k_q + 9'd1;
          if (last) state_d = StDone;
        end
      end
      StReadReq: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) state_d = StReadWait;
      end
      StReadWait: begin
        if (avm_readdatavalid) begin
          if ((avm_readdata != pattern) && (err_q != ErrMax)) err_d = err_q + 9'd1;
          k_d     = k_q + 9'd1;
          state_d = last ? StDone : StReadReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Write data is forced to zero whenever no write is being presented.
  assign avm_writedata = avm_write ? pattern : '0;
  assign busy          = (state_q == StWrite) || (state_q == StReadReq) ||
                         (state_q == StReadWait);
  assign done          = (state_q == StDone);
  assign pass          = done && (err_q == '0);
  assign error_count   = err_q;

endmodule

// File: tb/tb_master_example_test.sv
// Scoreboard bench: stimulus pushes expected bus commands and completion status,
// a monitor/slave process pops and compares as the master presents them.
module tb_master_example_test;

  localparam int unsigned AW = 26;
  localparam int unsigned DW = 32;
  localparam int unsigned NW = 16;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          n_action;
  logic          rdwr_cntl;
  logic [AW-1:0] address;
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic          avm_write;
  logic [DW-1:0] avm_writedata;
  logic [DW-1:0] avm_readdata;
  logic          avm_waitrequest;
  logic          avm_readdatavalid;
  logic          busy;
  logic          done;
  logic          pass;
  logic [8:0]    error_count;

  master_example_test #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NW)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .n_action          (n_action),
    .rdwr_cntl         (rdwr_cntl),
    .address           (address),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_readdata      (avm_readdata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .error_count       (error_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } bus_t;

  typedef struct {
    logic       pass;
    logic [8:0] err;
  } stat_t;

  bus_t          bus_q[$];
  stat_t         stat_q[$];
  logic [DW-1:0] mem[bit [AW-1:0]];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            acc_writes = 0;
  bit            rand_wait = 1'b0;
  bit            corrupt_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_action(input bit wr, input logic [AW-1:0] start, input logic exp_pass,
                             input logic [8:0] exp_err, input bit with_status);
    logic [AW-1:0] a;
    a = {start[AW-1:2], 2'b00};
    for (int k = 0; k < NW; k++) begin
      bus_q.push_back('{wr, a, DW'(a) ^ 32'hA5A5_0000});
      a = a + AW'(4);
    end
    if (with_status) stat_q.push_back('{exp_pass, exp_err});
  endtask

  // Monitor and Avalon slave model, one process so read responses stay ordered.
  bit            rd_pend = 1'b0;
  logic [AW-1:0] rd_addr;
  bit            stall_prev = 1'b0;
  bus_t          stall_cmd;
  bus_t          exp_cmd;
  stat_t         exp_st;
  logic          done_prev = 1'b0;
  logic [DW-1:0] rdata;

  always begin
    @(negedge clock);
    if (reset_n) begin
      if (avm_read || avm_write) check("rw_exclusive", 64'(avm_read & avm_write), 64'd0);
      if (stall_prev) begin
        check("stall_hold_write", 64'(avm_write), 64'(stall_cmd.wr));
        check("stall_hold_read", 64'(avm_read), 64'(!stall_cmd.wr));
        check("stall_hold_addr", 64'(avm_address), 64'(stall_cmd.addr));
        check("stall_hold_data", 64'(avm_writedata), 64'(stall_cmd.data));
      end
      stall_prev = (avm_read || avm_write) && avm_waitrequest;
      stall_cmd  = '{avm_write, avm_address, avm_writedata};
      if ((avm_read || avm_write) && !avm_waitrequest) begin
        if (bus_q.size() == 0) begin
          check("unexpected_cmd", 64'(avm_address), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_cmd = bus_q.pop_front();
          check("cmd_kind", 64'(avm_write), 64'(exp_cmd.wr));
          check("cmd_addr", 64'(avm_address), 64'(exp_cmd.addr));
          if (exp_cmd.wr) check("wr_data", 64'(avm_writedata), 64'(exp_cmd.data));
        end
        if (avm_write) begin
          mem[avm_address] = avm_writedata;
          acc_writes++;
        end else begin
          rd_pend = 1'b1;
          rd_addr = avm_address;
        end
      end
      if (done && !done_prev) begin
        if (stat_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_st = stat_q.pop_front();
          check("done_pass", 64'(pass), 64'(exp_st.pass));
          check("done_error_count", 64'(error_count), 64'(exp_st.err));
        end
      end
      done_prev = done;
    end else begin
      stall_prev = 1'b0;
      done_prev  = 1'b0;
      rd_pend    = 1'b0;
    end
    @(posedge clock);
    #1;
    rdata = mem.exists(rd_addr) ? mem[rd_addr] : '0;
    if (corrupt_en && (rd_addr == 26'h10C || rd_addr == 26'h11C)) rdata = rdata ^ 32'h1;
    avm_readdatavalid = rd_pend;
    avm_readdata      = rd_pend ? rdata : '0;
    rd_pend           = 1'b0;
    avm_waitrequest   = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  task automatic pulse(input logic rw, input logic [AW-1:0] a);
    @(posedge clock);
    #3;
    rdwr_cntl = rw;
    address   = a;
    n_action  = 1'b0;
    repeat (4) @(posedge clock);
    #3;
    n_action  = 1'b1;
    rdwr_cntl = 1'b1;
    address   = '0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int t = 0;
    while (done !== 1'b1 && t < budget) begin
      @(negedge clock);
      t++;
    end
    check(name, 64'(done), 64'd1);
    repeat (2) @(negedge clock);
    check("bus_queue_drained", 64'(bus_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int act;
    int acc0;
    int t;
    reset_n = 1'b0; n_action = 1'b1; rdwr_cntl = 1'b1; address = '0;
    avm_readdata = '0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_err", 64'(error_count), 64'd0);
    check("rst_cmd", 64'({avm_read, avm_write}), 64'd0);
    check("rst_addr", 64'(avm_address), 64'd0);
    check("rst_wdata", 64'(avm_writedata), 64'd0);
    reset_n = 1'b1;

    // Idle with n_action high: nothing may start.
    act = 0;
    repeat (200) begin
      @(negedge clock);
      if (avm_read || avm_write || busy || done) act++;
    end
    check("idle_activity", 64'(act), 64'd0);

    // Write 0x100..0x13C.
    push_action(1'b1, 26'h100, 1'b1, 9'd0, 1'b1);
    pulse(1'b0, 26'h100);
    check("write_busy", 64'(busy), 64'd1);
    wait_done("write_done", 100);

    // Clean read from an unaligned start.
    push_action(1'b0, 26'h103, 1'b1, 9'd0, 1'b1);
    pulse(1'b1, 26'h103);
    wait_done("read_done", 200);

    // Words 3 and 7 corrupted.
    corrupt_en = 1'b1;
    push_action(1'b0, 26'h100, 1'b0, 9'd2, 1'b1);
    pulse(1'b1, 26'h100);
    wait_done("read_corrupt_done", 200);
    corrupt_en = 1'b0;
    check("corrupt_err_hold", 64'(error_count), 64'd2);
    check("corrupt_pass_hold", 64'(pass), 64'd0);

    // Random stalls, plus a start pulse that arrives while busy.
    acc0 = acc_writes;
    rand_wait = 1'b1;
    push_action(1'b1, 26'h200, 1'b1, 9'd0, 1'b1);
    pulse(1'b0, 26'h200);
    pulse(1'b0, 26'h300);
    wait_done("rand_write_done", 400);
    rand_wait = 1'b0;
    check("rand_write_count", 64'(acc_writes - acc0), 64'd16);
    repeat (10) @(negedge clock);
    check("second_pulse_ignored", 64'(busy), 64'd0);

    // Wrap-around write, then abort a read of the same region with reset.
    push_action(1'b1, 26'h3FF_FFF8, 1'b1, 9'd0, 1'b1);
    pulse(1'b0, 26'h3FF_FFF8);
    wait_done("wrap_write_done", 100);
    push_action(1'b0, 26'h3FF_FFF8, 1'b1, 9'd0, 1'b0);
    pulse(1'b1, 26'h3FF_FFF8);
    t = 0;
    while (bus_q.size() > 12 && t < 200) begin
      @(negedge clock);
      t++;
    end
    t = 0;
    while (avm_read !== 1'b1 && t < 20) begin
      @(negedge clock);
      t++;
    end
    check("abort_read_seen", 64'(avm_read), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_read_drop", 64'(avm_read), 64'd0);
    check("abort_write_drop", 64'(avm_write), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_addr", 64'(avm_address), 64'd0);
    bus_q.delete();
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    act = 0;
    repeat (20) begin
      @(negedge clock);
      if (avm_read || avm_write || busy || done) act++;
    end
    check("post_abort_idle", 64'(act), 64'd0);
    check("status_queue_drained", 64'(stat_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
